// File: rtl/gated_blink_bank.sv
// gated_blink_bank: N independent LED blink channels on one clock.
// Each channel freezes its divider with a logic clock-enable rather than a
// gated clock, so the channel count does not cost clock-tree resources.
// Input path: optional inversion, 2-flop synchroniser, optional debouncer
// (compiled in when GATED_BLINK_DEBOUNCE_EN is defined), then per-channel
// level or toggle run/stop control.

// One blink channel: run/stop control plus a frozen-when-stopped divider.
module gated_blink_lane #(
    parameter int CNT_W       = 32,
    parameter int PERIOD      = 13500000,
    parameter int TOGGLE_MODE = 0
) (
    input  logic clk,
    input  logic rst_i,
    input  logic key_i,      // synchronised, active-high press level
    output logic led_o,
    output logic running_o
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(PERIOD - 1);

    logic             key_q;
    logic             run_q, run_d;
    logic             led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Run/stop: level mode follows the key, toggle mode flips on each press edge.
    always_comb begin
        run_d = run_q;
        if (TOGGLE_MODE != 0) begin
            if (key_i && !key_q) run_d = ~run_q;
        end else begin
            run_d = key_i;
        end
    end

    // Divider only advances while running; a stop freezes count and LED,
    // so a stop on the terminal count defers the wrap to the next run cycle.
    always_comb begin
        cnt_d = cnt_q;
        led_d = led_q;
        if (run_q) begin
            if (cnt_q == TERM) begin
                cnt_d = '0;
                led_d = ~led_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset wins over any press edge seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            key_q <= 1'b0;
            run_q <= (TOGGLE_MODE != 0);
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            key_q <= key_i;
            run_q <= run_d;
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led_o     = led_q;
    assign running_o = run_q;
endmodule

// Top level: buttons in, LEDs and run status out.
module gated_blink_bank #(
    parameter int CHANNELS    = 3,
    parameter int CNT_W       = 32,
    parameter int PERIOD      = 13500000,
    parameter int INV_BTN     = 1,
    parameter int TOGGLE_MODE = 0
`ifdef GATED_BLINK_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 270000
`endif
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] key_i,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] running
);
    localparam logic [CHANNELS-1:0] INV_MASK = (INV_BTN != 0) ? '1 : '0;

    logic [CHANNELS-1:0] key_n;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] key_s_q;
    logic [CHANNELS-1:0] key_en;

    // Normalise to active-high so every later stage sees 1 = pressed.
    assign key_n = key_i ^ INV_MASK;

    // Two-flop synchroniser; resets to "not pressed".
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync1_q <= '0;
            key_s_q <= '0;
        end else begin
            sync1_q <= key_n;
            key_s_q <= sync1_q;
        end
    end

`ifdef GATED_BLINK_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [CHANNELS-1:0]           key_db_q, key_db_d;

    // Adopt key_s only after it has differed from the debounced value for
    // DEBOUNCE_CYCLES consecutive clocks; any bounce back restarts the count.
    always_comb begin
        db_cnt_d = db_cnt_q;
        key_db_d = key_db_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (key_s_q[i] == key_db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_TERM) begin
                db_cnt_d[i] = '0;
                key_db_d[i] = key_s_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            db_cnt_q <= '0;
            key_db_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
            key_db_q <= key_db_d;
        end
    end

    assign key_en = key_db_q;
`else
    assign key_en = key_s_q;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        gated_blink_lane #(
            .CNT_W      (CNT_W),
            .PERIOD     (PERIOD),
            .TOGGLE_MODE(TOGGLE_MODE)
        ) u_lane (
            .clk      (clk),
            .rst_i    (rst_i),
            .key_i    (key_en[g]),
            .led_o    (led[g]),
            .running_o(running[g])
        );
    end
endmodule

// File: tb/tb_gated_blink_bank.sv
// Bench for gated_blink_bank: a level-mode and a toggle-mode instance share
// one clock. Each step pushes the expected outputs of both instances into a
// scoreboard; scenario tasks pop and compare at the following negedge.
// Expected LED = parity of (enabled cycles / PERIOD); expected running is
// derived from the key history and the fixed input latency.
module tb_gated_blink_bank;
    localparam int P = 4;
`ifdef GATED_BLINK_DEBOUNCE_EN
    localparam int DLY = 5;
`else
    localparam int DLY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_l, rst_t;
    logic [2:0] key_l, key_t;
    logic [2:0] led_l, run_l, led_t, run_t;

    always #5 clk = ~clk;

    gated_blink_bank #(
        .CHANNELS(3), .CNT_W(8), .PERIOD(P), .INV_BTN(0), .TOGGLE_MODE(0)
`ifdef GATED_BLINK_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(5)
`endif
    ) u_lvl (
        .clk(clk), .rst_i(rst_l), .key_i(key_l), .led(led_l), .running(run_l)
    );

    gated_blink_bank #(
        .CHANNELS(3), .CNT_W(8), .PERIOD(P), .INV_BTN(0), .TOGGLE_MODE(1)
`ifdef GATED_BLINK_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(5)
`endif
    ) u_tgl (
        .clk(clk), .rst_i(rst_t), .key_i(key_t), .led(led_t), .running(run_t)
    );

    typedef struct packed {
        logic [2:0] led_l;
        logic [2:0] run_l;
        logic [2:0] led_t;
        logic [2:0] run_t;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] kh_l[16];
    logic [2:0] kh_t[16];
    logic [2:0] rm_l, rm_t;
    int         en_l[3];
    int         en_t[3];
    int         tests = 0;
    int         fails = 0;

    // Drive one clock of stimulus and push the expected outputs after it.
    task automatic step(input logic [2:0] kl, input logic rl,
                        input logic [2:0] kt, input logic rt);
        exp_t e;
        key_l = kl; rst_l = rl; key_t = kt; rst_t = rt;
        @(posedge clk);
        if (rl) begin
            for (int i = 0; i < 16; i++) kh_l[i] = '0;
            rm_l = '0;
            for (int c = 0; c < 3; c++) en_l[c] = 0;
        end else begin
            for (int c = 0; c < 3; c++) if (rm_l[c]) en_l[c]++;
            for (int i = 15; i > 0; i--) kh_l[i] = kh_l[i-1];
            kh_l[0] = kl;
            rm_l = kh_l[2+DLY];
        end
        if (rt) begin
            for (int i = 0; i < 16; i++) kh_t[i] = '0;
            rm_t = '1;
            for (int c = 0; c < 3; c++) en_t[c] = 0;
        end else begin
            for (int c = 0; c < 3; c++) if (rm_t[c]) en_t[c]++;
            for (int i = 15; i > 0; i--) kh_t[i] = kh_t[i-1];
            kh_t[0] = kt;
            rm_t = rm_t ^ (kh_t[2+DLY] & ~kh_t[3+DLY]);
        end
        for (int c = 0; c < 3; c++) begin
            e.led_l[c] = ((en_l[c] / P) % 2) != 0;
            e.led_t[c] = ((en_t[c] / P) % 2) != 0;
        end
        e.run_l = rm_l;
        e.run_t = rm_t;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            step(3'b111, 1'b1, 3'b111, 1'b1);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== {3'b000, 3'b000, 3'b000, 3'b111}) begin
                fails++;
                $display("FAIL reset: got led_l=%b run_l=%b led_t=%b run_t=%b, want 000 000 000 111",
                         led_l, run_l, led_t, run_t);
            end
        end
    endtask

    task automatic test_level_run();
        exp_t e;
        for (int t = 1; t <= 20; t++) begin
            step(3'b001, 1'b0, 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL level_run t=%0d: got %b %b %b %b, want %b %b %b %b", t,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
            if (t == 2 + DLY || t == 3 + DLY) begin
                tests++;
                if (run_l !== ((t == 3 + DLY) ? 3'b001 : 3'b000)) begin
                    fails++;
                    $display("FAIL level_latency t=%0d: running=%b", t, run_l);
                end
            end
            if (t == 6 + DLY || t == 7 + DLY) begin
                tests++;
                if (led_l !== ((t == 7 + DLY) ? 3'b001 : 3'b000)) begin
                    fails++;
                    $display("FAIL level_first_toggle t=%0d: led=%b", t, led_l);
                end
            end
        end
    endtask

    // Stop channel 0 so its counter freezes at frz, then resume.
    task automatic test_stop_resume(input string nm, input int frz);
        exp_t e;
        int   tgt;
        logic led0;
        tgt  = (((frz - 3 - DLY) % P) + P) % P;
        led0 = 1'b0;
        for (int i = 0; i < 2 * P && (en_l[0] % P) != tgt; i++) begin
            step(3'b001, 1'b0, 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL %s_align: got %b %b %b %b, want %b %b %b %b", nm,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 1'b0, 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL %s_stop i=%0d: got %b %b %b %b, want %b %b %b %b", nm, i,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
            if (i == 2 + DLY) led0 = e.led_l[0];
            if (i > 2 + DLY) begin
                tests++;
                if (led_l[0] !== led0 || run_l[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_frozen i=%0d: led0=%b run0=%b, want led0=%b run0=0",
                             nm, i, led_l[0], run_l[0], led0);
                end
            end
        end
        for (int j = 0; j < 12; j++) begin
            step(3'b001, 1'b0, 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL %s_resume j=%0d: got %b %b %b %b, want %b %b %b %b", nm, j,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
            if (j == 1 + DLY + P - frz || j == 2 + DLY + P - frz) begin
                tests++;
                if (led_l[0] !== ((j == 2 + DLY + P - frz) ? ~led0 : led0)) begin
                    fails++;
                    $display("FAIL %s_resume_toggle j=%0d: led0=%b frozen=%b", nm, j, led_l[0], led0);
                end
            end
        end
    endtask

    task automatic test_toggle_mode();
        exp_t e;
        int   flips;
        logic prev;
        flips = 0;
        prev  = run_t[1];
        for (int i = 0; i < 46; i++) begin
            step(3'b000, 1'b0,
                 (i < 20 || (i >= 30 && i < 38)) ? 3'b010 : 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL toggle i=%0d: got %b %b %b %b, want %b %b %b %b", i,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
            if (i < 30 && run_t[1] !== prev) flips++;
            prev = run_t[1];
            if (i == 2 + DLY) begin
                tests++;
                if (run_t[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL toggle_latency: running[1]=%b, want 0", run_t[1]);
                end
            end
        end
        tests++;
        if (flips !== 1) begin
            fails++;
            $display("FAIL toggle_held_once: flips=%0d, want 1", flips);
        end
        tests++;
        if (run_t !== 3'b111) begin
            fails++;
            $display("FAIL toggle_restore: running=%b, want 111", run_t);
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [2:0] r0;
        r0 = run_t;
        for (int i = 0; i < 12; i++) begin
            step(3'b111, 1'b0, 3'b111, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL simultaneous i=%0d: got %b %b %b %b, want %b %b %b %b", i,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
            if (i == 2 + DLY) begin
                tests++;
                if (run_l !== 3'b111 || run_t !== ~r0) begin
                    fails++;
                    $display("FAIL simultaneous_same_cycle: run_l=%b run_t=%b, want 111 %b",
                             run_l, run_t, ~r0);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 1'b0, 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL simultaneous_release i=%0d: got %b %b %b %b, want %b %b %b %b", i,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        step(3'b000, 1'b1, 3'b000, 1'b0);
        e = sb.pop_front();
        for (int t = 1; t <= 8 + DLY; t++) begin
            step(3'b101, 1'b0, (t >= 7) ? 3'b010 : 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL reset_mid_pre t=%0d: got %b %b %b %b, want %b %b %b %b", t,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
        end
        tests++;
        if (led_l !== 3'b101) begin
            fails++;
            $display("FAIL reset_mid_setup: led=%b, want 101", led_l);
        end
        step(3'b101, 1'b1, 3'b010, 1'b1);
        e = sb.pop_front();
        tests++;
        if ({led_l, run_l, led_t, run_t} !== {3'b000, 3'b000, 3'b000, 3'b111}) begin
            fails++;
            $display("FAIL reset_mid: got led_l=%b run_l=%b led_t=%b run_t=%b, want 000 000 000 111",
                     led_l, run_l, led_t, run_t);
        end
        for (int i = 0; i < 16; i++) begin
            step(3'b101, 1'b0, (i < 8) ? 3'b010 : 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if ({led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL reset_mid_post i=%0d: got %b %b %b %b, want %b %b %b %b", i,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
        end
    endtask

`ifdef GATED_BLINK_DEBOUNCE_EN
    task automatic test_debounce();
        exp_t e;
        step(3'b000, 1'b1, 3'b000, 1'b1);
        e = sb.pop_front();
        for (int t = 1; t <= 16; t++) begin
            step((t <= 4) ? 3'b001 : 3'b000, 1'b0, 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if (run_l !== 3'b000 || led_l !== 3'b000) begin
                fails++;
                $display("FAIL debounce_short t=%0d: running=%b led=%b, want 000 000", t, run_l, led_l);
            end
        end
        step(3'b000, 1'b1, 3'b000, 1'b1);
        e = sb.pop_front();
        for (int t = 1; t <= 18; t++) begin
            step((t <= 6) ? 3'b001 : 3'b000, 1'b0, 3'b000, 1'b0);
            e = sb.pop_front();
            tests++;
            if (run_l[0] !== (t >= 8 && t <= 13) || {led_l, run_l, led_t, run_t} !== e) begin
                fails++;
                $display("FAIL debounce_long t=%0d: got %b %b %b %b, want %b %b %b %b", t,
                         led_l, run_l, led_t, run_t, e.led_l, e.run_l, e.led_t, e.run_t);
            end
        end
    endtask
`endif

    initial begin
        key_l = '0; key_t = '0; rst_l = 1'b1; rst_t = 1'b1;
        rm_l = '0; rm_t = '1;
        for (int i = 0; i < 16; i++) begin kh_l[i] = '0; kh_t[i] = '0; end
        for (int c = 0; c < 3; c++) begin en_l[c] = 0; en_t[c] = 0; end
        @(negedge clk);
        test_reset();
        test_level_run();
        test_stop_resume("freeze", 2);
        test_stop_resume("terminal", 3);
        test_toggle_mode();
        test_back_to_back();
        test_reset_mid();
`ifdef GATED_BLINK_DEBOUNCE_EN
        test_debounce();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, tests=%0d", tests);
        $fatal(1);
    end
endmodule
